// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - register busy scoreboard with issue stall, writeback enable and busy count
// Optional macro ZERO_REG_EN hardwires register 0 (never busy, never written back).
module reg_scoreboard #(
    parameter  int ADDR_W = 5,
    localparam int NREGS  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic [ADDR_W-1:0] issue_rs1,
    input  logic [ADDR_W-1:0] issue_rs2,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              flush,
    output logic              stall,
    output logic [NREGS-1:0]  busy,
    output logic [NREGS-1:0]  wb_we,
    output logic [ADDR_W:0]   busy_cnt
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] wb_we_q, wb_we_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;
    logic [NREGS-1:0] set_vec, clr_vec;

    // Hazard check looks only at registered busy: a same-cycle writeback does not unblock.
    assign stall = issue_valid & (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid && !stall && !flush) begin
            set_vec[issue_rd] = 1'b1;
        end
        if (wb_valid) begin
            clr_vec[wb_rd] = 1'b1;
        end
`ifdef ZERO_REG_EN
        set_vec[0] = 1'b0;
        clr_vec[0] = 1'b0;
`endif
        // Set is applied after clear so a same-register collision leaves the bit busy.
        busy_d  = flush ? '0 : ((busy_q & ~clr_vec) | set_vec);
        wb_we_d = clr_vec;
        cnt_d   = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            wb_we_q <= '0;
            cnt_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            wb_we_q <= wb_we_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign wb_we    = wb_we_q;
    assign busy_cnt = cnt_q;

endmodule
